// File: rtl/rv_pkg.sv
// Shared definitions for the RV32 front end: widths, reset PC, NOP encoding,
// opcode field position and the fetch FSM state encoding.
package rv_pkg;

    localparam int          RV_XLEN     = 32;
    localparam int          ILEN        = 32;
    localparam logic [31:0] RV_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] RV_NOP      = 32'h0000_0013;

    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 6;
    localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } ifu_state_e;

    function automatic logic [OPC_W-1:0] opcode_of(input logic [ILEN-1:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/rv_ifu_skid.sv
// One-entry instruction+PC holding buffer with push/pop/clear.
// Clear has priority; push with pop in the same cycle replaces the entry.
module rv_ifu_skid
    import rv_pkg::*;
#(
    parameter int XLEN = RV_XLEN
)(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic            i_clear,
    input  logic [ILEN-1:0] i_instr,
    input  logic [XLEN-1:0] i_pc,
    output logic            o_valid,
    output logic [ILEN-1:0] o_instr,
    output logic [XLEN-1:0] o_pc
);

    logic            r_valid;
    logic [ILEN-1:0] r_instr;
    logic [XLEN-1:0] r_pc;

    // Occupancy flag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)     r_valid <= 1'b0;
        else if (i_clear) r_valid <= 1'b0;
        else if (i_push)  r_valid <= 1'b1;
        else if (i_pop)   r_valid <= 1'b0;
    end

    // Payload capture; contents are only meaningful while r_valid is set
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule

// File: rtl/rv_ifu.sv
// RV32 instruction fetch unit with IF/ID pipeline register.
// One outstanding imem request; redirect/flush/stall handling with a
// one-entry skid buffer. Optional RV_IFU_MISALIGN_CHK_EN reports misaligned
// redirect targets through id_misalign_o instead of masking them.
module rv_ifu
    import rv_pkg::*;
#(
    parameter int              XLEN     = RV_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RV_RESET_PC)
)(
    input  logic            clk_i,
    input  logic            rst_n_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            flush_i,
    input  logic            id_stall_i,
    output logic            id_valid_o,
    output logic [31:0]     id_instr_o,
    output logic [XLEN-1:0] id_pc_o,
    output logic [6:0]      id_opcode_o,
    output logic            if_busy_o
`ifdef RV_IFU_MISALIGN_CHK_EN
    ,
    output logic            id_misalign_o
`endif
);

    ifu_state_e      r_state, w_state_nxt;
    logic [XLEN-1:0] r_pc, r_fetch_pc;
    logic            r_kill, r_hold;
    logic            r_id_valid;
    logic [31:0]     r_id_instr;
    logic [XLEN-1:0] r_id_pc;
`ifdef RV_IFU_MISALIGN_CHK_EN
    logic            r_id_misal;
`endif

    logic            w_skid_valid, w_skid_push, w_skid_pop, w_skid_clear;
    logic [31:0]     w_skid_instr;
    logic [XLEN-1:0] w_skid_pc;
    logic            w_fire, w_rsp, w_rsp_ok, w_stall_hold, w_stuck;
    logic            w_mis, w_hold_nxt;
    logic [XLEN-1:0] w_redir_pc;

`ifdef RV_IFU_MISALIGN_CHK_EN
    assign w_mis = redirect_i & (redirect_pc_i[1:0] != 2'b00);
`else
    assign w_mis = 1'b0;
`endif

    // Misaligned redirect parks the FSM in IDLE until the next redirect
    assign w_hold_nxt   = redirect_i ? w_mis : r_hold;
    assign w_redir_pc   = {redirect_pc_i[XLEN-1:2], 2'b00};
    assign w_fire       = imem_req_o & imem_gnt_i;
    assign w_rsp        = (r_state == ST_WAIT) & imem_rvalid_i;
    // Killed responses and responses racing a flush/redirect are discarded
    assign w_rsp_ok     = w_rsp & ~r_kill & ~redirect_i & ~flush_i;
    assign w_stall_hold = id_stall_i & r_id_valid;
    assign w_stuck      = w_rsp_ok & w_stall_hold & w_skid_valid;

    assign w_skid_clear = flush_i | redirect_i;
    assign w_skid_pop   = ~w_skid_clear & ~w_stall_hold & w_skid_valid;
    assign w_skid_push  = w_rsp_ok & (w_stall_hold ? ~w_skid_valid : w_skid_valid);

    rv_ifu_skid #(.XLEN(XLEN)) u_skid (
        .i_clk   (clk_i),
        .i_rst_n (rst_n_i),
        .i_push  (w_skid_push),
        .i_pop   (w_skid_pop),
        .i_clear (w_skid_clear),
        .i_instr (imem_rdata_i),
        .i_pc    (r_fetch_pc),
        .o_valid (w_skid_valid),
        .o_instr (w_skid_instr),
        .o_pc    (w_skid_pc)
    );

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (!w_hold_nxt) w_state_nxt = ST_REQ;
            ST_REQ: begin
                if (w_fire)     w_state_nxt = ST_WAIT;
                else if (w_mis) w_state_nxt = ST_IDLE;
            end
            ST_WAIT: begin
                if (w_rsp && !w_stuck) w_state_nxt = w_hold_nxt ? ST_IDLE : ST_REQ;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: request only while the skid buffer has room
    always_comb begin
        imem_req_o  = (r_state == ST_REQ) & ~w_skid_valid;
        imem_addr_o = r_pc;
        if_busy_o   = (r_state == ST_REQ) | (r_state == ST_WAIT);
    end

    // PC, kill flag (drop next response) and misalign hold flag
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_pc   <= RESET_PC;
            r_kill <= 1'b0;
            r_hold <= 1'b0;
        end else begin
            if (redirect_i)  r_pc <= w_redir_pc;
            else if (w_fire) r_pc <= r_pc + XLEN'(4);
            if (redirect_i & (w_fire | ((r_state == ST_WAIT) & ~imem_rvalid_i)))
                r_kill <= 1'b1;
            else if (w_rsp)
                r_kill <= 1'b0;
            r_hold <= w_hold_nxt;
        end
    end

    // Address of the request in flight, paired with its response
    always_ff @(posedge clk_i) begin
        if (w_fire) r_fetch_pc <= r_pc;
    end

    // IF/ID register: flush/redirect, then stall hold, then skid, then response
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_id_valid <= 1'b0;
            r_id_instr <= RV_NOP;
            r_id_pc    <= '0;
`ifdef RV_IFU_MISALIGN_CHK_EN
            r_id_misal <= 1'b0;
`endif
        end else if (redirect_i | flush_i) begin
            r_id_valid <= w_mis;
            if (w_mis) begin
                r_id_instr <= RV_NOP;
                r_id_pc    <= redirect_pc_i;
            end
`ifdef RV_IFU_MISALIGN_CHK_EN
            r_id_misal <= w_mis;
`endif
        end else if (w_stall_hold) begin
            r_id_valid <= 1'b1;
        end else begin
            if (w_skid_valid) begin
                r_id_valid <= 1'b1;
                r_id_instr <= w_skid_instr;
                r_id_pc    <= w_skid_pc;
            end else if (w_rsp_ok) begin
                r_id_valid <= 1'b1;
                r_id_instr <= imem_rdata_i;
                r_id_pc    <= r_fetch_pc;
            end else begin
                r_id_valid <= 1'b0;
            end
`ifdef RV_IFU_MISALIGN_CHK_EN
            r_id_misal <= 1'b0;
`endif
        end
    end

    assign id_valid_o  = r_id_valid;
    assign id_instr_o  = r_id_instr;
    assign id_pc_o     = r_id_pc;
    assign id_opcode_o = opcode_of(r_id_instr);
`ifdef RV_IFU_MISALIGN_CHK_EN
    assign id_misalign_o = r_id_misal;
`endif

endmodule

// File: tb/tb_rv_ifu.sv
// Testbench for rv_ifu: cycle table of directed vectors, hand sequences for
// PC wrap and (with RV_IFU_MISALIGN_CHK_EN) misaligned redirect, then a
// randomized run against an instruction-stream reference model.
module tb_rv_ifu;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        flush_i;
    logic        id_stall_i;
    logic        id_valid_o;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_o;
    logic [6:0]  id_opcode_o;
    logic        if_busy_o;
`ifdef RV_IFU_MISALIGN_CHK_EN
    logic        id_misalign_o;
`endif

    rv_ifu dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .flush_i       (flush_i),
        .id_stall_i    (id_stall_i),
        .id_valid_o    (id_valid_o),
        .id_instr_o    (id_instr_o),
        .id_pc_o       (id_pc_o),
        .id_opcode_o   (id_opcode_o),
        .if_busy_o     (if_busy_o)
`ifdef RV_IFU_MISALIGN_CHK_EN
        ,
        .id_misalign_o (id_misalign_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_pass = 0;
    int n_total = 0;

    typedef struct packed {
        logic        stall;
        logic        flush;
        logic        redir;
        logic [31:0] rpc;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr;
        logic        idv;
        logic [31:0] idpc;
        logic [6:0]  opc;
        logic        busy;
    } vec_t;

    localparam int NROWS = 30;
    vec_t tbl [NROWS];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic vec_t mk(input logic st, input logic fl, input logic rd,
                                input logic [31:0] rpc, input logic g, input logic rv,
                                input logic [31:0] rdat, input logic rq, input logic [31:0] ad,
                                input logic iv, input logic [31:0] ipc, input logic [6:0] op,
                                input logic bz);
        vec_t v;
        v.stall = st; v.flush = fl; v.redir = rd; v.rpc = rpc; v.gnt = g; v.rv = rv;
        v.rdata = rdat; v.req = rq; v.addr = ad; v.idv = iv; v.idpc = ipc; v.opc = op;
        v.busy = bz;
        return v;
    endfunction

    // Memory contents used by the random phase
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return {a[31:2] ^ 30'h2AAA_AAAA, 2'b11};
    endfunction

    task automatic drive_idle();
        imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0;
        redirect_i = 0; redirect_pc_i = 0; flush_i = 0; id_stall_i = 0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req"},   32'(imem_req_o), 32'h0);
        check({tag, "_idv"},   32'(id_valid_o), 32'h0);
        check({tag, "_instr"}, id_instr_o,      32'h0000_0013);
        check({tag, "_idpc"},  id_pc_o,         32'h0);
        check({tag, "_busy"},  32'(if_busy_o),  32'h0);
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        v;
        logic [31:0] exp_pc, t, ei;
        logic        pend, pend_b;
        logic [31:0] paddr;
        int unsigned due;
        int          proto_err, consumed;

        //           st fl rd rpc          g  rv rdata         rq addr         iv idpc         opc    bz
        tbl[0]  = mk(0, 0, 0, 32'h0,       0, 0, 32'h0,        0, 32'h0,       0, 32'h0,       7'h00, 0);
        tbl[1]  = mk(0, 0, 0, 32'h0,       1, 0, 32'h0,        1, 32'h0,       0, 32'h0,       7'h00, 1);
        tbl[2]  = mk(0, 0, 0, 32'h0,       0, 1, 32'h00500093, 0, 32'h0,       0, 32'h0,       7'h00, 1);
        tbl[3]  = mk(0, 0, 0, 32'h0,       1, 0, 32'h0,        1, 32'h4,       1, 32'h0,       7'h13, 1);
        tbl[4]  = mk(0, 0, 0, 32'h0,       0, 1, 32'h002081B3, 0, 32'h0,       0, 32'h0,       7'h00, 1);
        tbl[5]  = mk(1, 0, 0, 32'h0,       1, 0, 32'h0,        1, 32'h8,       1, 32'h4,       7'h33, 1);
        tbl[6]  = mk(1, 0, 0, 32'h0,       0, 1, 32'h00000237, 0, 32'h0,       1, 32'h4,       7'h33, 1);
        tbl[7]  = mk(1, 0, 0, 32'h0,       0, 0, 32'h0,        0, 32'h0,       1, 32'h4,       7'h33, 1);
        tbl[8]  = mk(1, 0, 0, 32'h0,       0, 0, 32'h0,        0, 32'h0,       1, 32'h4,       7'h33, 1);
        tbl[9]  = mk(1, 0, 0, 32'h0,       0, 0, 32'h0,        0, 32'h0,       1, 32'h4,       7'h33, 1);
        tbl[10] = mk(0, 0, 0, 32'h0,       0, 0, 32'h0,        0, 32'h0,       1, 32'h4,       7'h33, 1);
        tbl[11] = mk(0, 0, 0, 32'h0,       1, 0, 32'h0,        1, 32'hC,       1, 32'h8,       7'h37, 1);
        tbl[12] = mk(0, 0, 0, 32'h0,       0, 1, 32'h0040006F, 0, 32'h0,       0, 32'h0,       7'h00, 1);
        tbl[13] = mk(0, 0, 0, 32'h0,       1, 0, 32'h0,        1, 32'h10,      1, 32'hC,       7'h6F, 1);
        tbl[14] = mk(0, 0, 1, 32'h100,     0, 0, 32'h0,        0, 32'h0,       0, 32'h0,       7'h00, 1);
        tbl[15] = mk(0, 0, 0, 32'h0,       0, 1, 32'hDEADBEEF, 0, 32'h0,       0, 32'h0,       7'h00, 1);
        tbl[16] = mk(0, 0, 0, 32'h0,       1, 0, 32'h0,        1, 32'h100,     0, 32'h0,       7'h00, 1);
        tbl[17] = mk(0, 0, 0, 32'h0,       0, 1, 32'h00000517, 0, 32'h0,       0, 32'h0,       7'h00, 1);
        tbl[18] = mk(1, 0, 0, 32'h0,       1, 0, 32'h0,        1, 32'h104,     1, 32'h100,     7'h17, 1);
        tbl[19] = mk(1, 0, 0, 32'h0,       0, 1, 32'h00412283, 0, 32'h0,       1, 32'h100,     7'h17, 1);
        tbl[20] = mk(1, 1, 0, 32'h0,       0, 0, 32'h0,        0, 32'h0,       1, 32'h100,     7'h17, 1);
        tbl[21] = mk(0, 0, 0, 32'h0,       0, 0, 32'h0,        1, 32'h108,     0, 32'h0,       7'h00, 1);
        tbl[22] = mk(0, 0, 1, 32'h200,     0, 0, 32'h0,        1, 32'h108,     0, 32'h0,       7'h00, 1);
        tbl[23] = mk(0, 0, 0, 32'h0,       1, 0, 32'h0,        1, 32'h200,     0, 32'h0,       7'h00, 1);
        tbl[24] = mk(0, 0, 1, 32'h300,     0, 1, 32'h11111111, 0, 32'h0,       0, 32'h0,       7'h00, 1);
        tbl[25] = mk(0, 0, 1, 32'h400,     1, 0, 32'h0,        1, 32'h300,     0, 32'h0,       7'h00, 1);
        tbl[26] = mk(0, 0, 0, 32'h0,       0, 1, 32'h22222222, 0, 32'h0,       0, 32'h0,       7'h00, 1);
        tbl[27] = mk(0, 0, 0, 32'h0,       1, 0, 32'h0,        1, 32'h400,     0, 32'h0,       7'h00, 1);
        tbl[28] = mk(0, 0, 0, 32'h0,       0, 1, 32'h00C58633, 0, 32'h0,       0, 32'h0,       7'h00, 1);
        tbl[29] = mk(0, 0, 0, 32'h0,       0, 0, 32'h0,        1, 32'h404,     1, 32'h400,     7'h33, 1);

        // Power-up reset
        rst_n_i = 0;
        drive_idle();
        tick();
        tick();
        check_reset("por");
        rst_n_i = 1;

        // Directed cycle table
        for (int i = 0; i < NROWS; i++) begin
            v = tbl[i];
            id_stall_i    = v.stall;
            flush_i       = v.flush;
            redirect_i    = v.redir;
            redirect_pc_i = v.rpc;
            imem_gnt_i    = v.gnt;
            imem_rvalid_i = v.rv;
            imem_rdata_i  = v.rdata;
            check($sformatf("row%0d_req", i), 32'(imem_req_o), 32'(v.req));
            if (v.req) check($sformatf("row%0d_addr", i), imem_addr_o, v.addr);
            check($sformatf("row%0d_idv", i), 32'(id_valid_o), 32'(v.idv));
            if (v.idv) begin
                check($sformatf("row%0d_idpc", i), id_pc_o, v.idpc);
                check($sformatf("row%0d_opc", i), 32'(id_opcode_o), 32'(v.opc));
            end
            check($sformatf("row%0d_busy", i), 32'(if_busy_o), 32'(v.busy));
            tick();
        end
        drive_idle();

        // PC wrap at the top of the address space (low target bits masked by default)
        redirect_i = 1;
`ifdef RV_IFU_MISALIGN_CHK_EN
        redirect_pc_i = 32'hFFFF_FFFC;
`else
        redirect_pc_i = 32'hFFFF_FFFE;
`endif
        tick();
        redirect_i = 0;
        check("wrap_req0", 32'(imem_req_o), 32'h1);
        check("wrap_addr0", imem_addr_o, 32'hFFFF_FFFC);
        imem_gnt_i = 1;
        tick();
        imem_gnt_i = 0;
        check("wrap_wait_req", 32'(imem_req_o), 32'h0);
        imem_rvalid_i = 1; imem_rdata_i = 32'h0000_0013;
        tick();
        imem_rvalid_i = 0;
        check("wrap_req1", 32'(imem_req_o), 32'h1);
        check("wrap_addr1", imem_addr_o, 32'h0);
        check("wrap_idv", 32'(id_valid_o), 32'h1);
        check("wrap_idpc", id_pc_o, 32'hFFFF_FFFC);

`ifdef RV_IFU_MISALIGN_CHK_EN
        // Misaligned redirect: reported in IF/ID, no fetch until next redirect
        redirect_i = 1; redirect_pc_i = 32'h102;
        tick();
        redirect_i = 0;
        check("mis_idv", 32'(id_valid_o), 32'h1);
        check("mis_flag", 32'(id_misalign_o), 32'h1);
        check("mis_idpc", id_pc_o, 32'h102);
        check("mis_instr", id_instr_o, 32'h0000_0013);
        check("mis_req", 32'(imem_req_o), 32'h0);
        tick();
        check("mis_idv_after", 32'(id_valid_o), 32'h0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("mis_noreq%0d", i), 32'(imem_req_o), 32'h0);
            tick();
        end
        redirect_i = 1; redirect_pc_i = 32'h200;
        tick();
        redirect_i = 0;
        check("mis_resume_req", 32'(imem_req_o), 32'h1);
        check("mis_resume_addr", imem_addr_o, 32'h200);
        check("mis_flag_clr", 32'(id_misalign_o), 32'h0);
`endif

        // Reset asserted mid-run
        rst_n_i = 0;
        drive_idle();
        #1;
        check_reset("midrst");
        tick();
        tick();
        rst_n_i = 1;

        // Randomized run: consumed instructions must form the sequential stream
        // starting at the reset PC, restarting at each redirect target.
        exp_pc = 32'h0; pend = 0; paddr = 0; due = 0; proto_err = 0; consumed = 0;
        for (int unsigned c = 0; c < 3000; c++) begin
            pend_b = pend;
            if (imem_req_o && pend_b) proto_err++;
            if (imem_req_o && (imem_addr_o[1:0] != 2'b00)) proto_err++;
            imem_rvalid_i = 0;
            imem_rdata_i  = $urandom;
            if (pend && c == due) begin
                imem_rvalid_i = 1;
                imem_rdata_i  = instr_of(paddr);
                pend = 0;
            end
            imem_gnt_i = imem_req_o && !pend_b && ($urandom_range(0, 3) != 0);
            if (imem_gnt_i) begin
                pend  = 1;
                paddr = imem_addr_o;
                due   = c + $urandom_range(1, 3);
            end
            id_stall_i = ($urandom_range(0, 9) < 3);
            redirect_i = ($urandom_range(0, 49) == 0);
            t = $urandom;
            if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFE0 | (t & 32'h1F);
`ifdef RV_IFU_MISALIGN_CHK_EN
            t[1:0] = 2'b00;
`endif
            redirect_pc_i = t;
            if (redirect_i) begin
                exp_pc = t & 32'hFFFF_FFFC;
            end else if (id_valid_o && !id_stall_i) begin
                ei = instr_of(exp_pc);
                check("rnd_pc", id_pc_o, exp_pc);
                check("rnd_instr", id_instr_o, ei);
                check("rnd_opc", 32'(id_opcode_o), 32'(ei[6:0]));
                exp_pc = exp_pc + 32'h4;
                consumed++;
            end
            tick();
        end
        drive_idle();
        check("rnd_protocol_errors", 32'(proto_err), 32'h0);
        check("rnd_progress", 32'(consumed > 200), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
